instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the MIPS pipeline CPU: owns the PC, issues word requests to instruction memory over a req/ack handshake, and fills the IF/ID pipeline register that feeds the Decode stage. It honours stalls from the hazard unit by buffering one returned instruction. It redirects on J/JR/taken-branch requests and flushes wrong-path instructions to a NOP (32'h0000_0000, sll $0,$0,0).

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset (word aligned).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address; bits[1:0] always 0.
- imem_ack  in  1  response valid this cycle; imem_rdata sampled on the same edge.
- imem_rdata  in  32  fetched instruction.
- stall  in  1  hazard unit: hold IF/ID contents.
- redirect  in  1  control transfer: flush and fetch from redirect_pc.
- redirect_pc  in  32  target address; bits[1:0] ignored and forced to 0.
- IF_ID_instr  out  32  instruction to Decode.
- IF_ID_pc4  out  32  address of IF_ID_instr plus 4.
- IF_ID_valid  out  1  IF_ID_instr is a real fetched instruction.

## Operation
- Registers: pc (next address), req_addr (outstanding address), hold_instr/hold_pc4 (one-entry skid buffer), state.
- States: IDLE, FETCH, HOLD, DROP.
  - IDLE: entered only from reset. Go to FETCH on the next clock.
  - FETCH: imem_req=1, imem_addr=req_addr. On imem_ack, if IF/ID is free (!stall or !IF_ID_valid): load IF_ID_instr=imem_rdata, IF_ID_pc4=req_addr+4, IF_ID_valid=1, then pc and req_addr become req_addr+4, staying in FETCH. On imem_ack with IF/ID blocked: store the word in the hold buffer and go to HOLD.
  - HOLD: imem_req=0. When stall is low, move the buffer into IF/ID, advance pc and req_addr, and go to FETCH.
  - DROP: imem_req=1 with the old req_addr held. On imem_ack, discard the data, set req_addr=pc and go to FETCH.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay stable until imem_ack. A request is never retracted.
- Redirect has the highest priority in every state:
  - IF_ID_valid=0, IF_ID_instr=0, IF_ID_pc4 unchanged, hold buffer invalidated, pc={redirect_pc[31:2],2'b00}.
  - FETCH with imem_ack in the same cycle: discard the data, set req_addr to the target, stay in FETCH.
  - FETCH without imem_ack: go to DROP.
  - HOLD or IDLE: go to FETCH with req_addr at the target.
  - DROP: update pc only and stay in DROP.
- Redirect and stall together: redirect wins and IF/ID is flushed.
- Stall while IF_ID_valid=0 does not block loading.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, IF_ID_instr=0, IF_ID_pc4=0, IF_ID_valid=0, state IDLE.
- First imem_req=1 appears in the first cycle after the first rising edge with rst_n high.
- Latency from imem_ack to IF/ID load is 1 clock (registered).
- With zero-wait memory (ack in the same cycle as req), throughput is 1 instruction per clock.
- Redirect to the first request at the target is 1 clock when no fetch is outstanding. Otherwise it takes DROP time plus 1.
- If reset is asserted mid-operation, all state clears immediately (asynchronously). An outstanding request is abandoned and the memory must tolerate this.

## Configuration
- IFU_FETCH_CNT_EN:
  - Defined: adds output fetch_cnt (32 bits), reset to 0. It increments by 1 on every IF/ID load from memory or from the hold buffer, wraps at 2^32, and does not count discarded words.
  - Undefined: the port and its counter do not exist.

## Test plan
- Reset, then zero-wait memory returning 32'h0800000b, 32'h20080042 -> IF_ID_instr=32'h0800000b with IF_ID_pc4=4 one clock after the first ack; next clock 32'h20080042 with pc4=8.
- Ack of 32'h01095022 while stall=1 and IF_ID_valid=1 -> imem_req=0 and IF/ID unchanged; after stall falls, IF_ID_instr=32'h01095022 the next clock.
- redirect=1, redirect_pc=32'h2C with no fetch outstanding -> IF_ID_valid=0, IF_ID_instr=0; the next request has imem_addr=32'h2C.
- redirect_pc=32'h07 while a request to 32'h10 is outstanding -> imem_addr stays 32'h10 until ack; that data is dropped; the next request is to 32'h04.
- redirect and stall asserted together with a valid 32'hac0b000c in IF/ID -> IF/ID flushed to 0/valid=0.
- With IFU_FETCH_CNT_EN, 5 loads plus 1 dropped word -> fetch_cnt=5.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, one-entry skid buffer, IF/ID register.
// Optional fetch counter output enabled by defining IFU_FETCH_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid
`ifdef IFU_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, req_addr, hold_instr, hold_pc4;
  logic [31:0] target;
  logic        ifid_free, load_mem, load_hold, capture_hold, retarget;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign ifid_free = !stall || !IF_ID_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (redirect)                    state_next = imem_ack ? FETCH : DROP;
        else if (imem_ack && !ifid_free) state_next = HOLD;
      end
      HOLD:  if (redirect || !stall) state_next = FETCH;
      DROP:  if (!redirect && imem_ack) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req     = (state == FETCH) || (state == DROP);
    imem_addr    = req_addr;
    load_mem     = (state == FETCH) && imem_ack && !redirect && ifid_free;
    capture_hold = (state == FETCH) && imem_ack && !redirect && !ifid_free;
    load_hold    = (state == HOLD) && !redirect && !stall;
    // A redirect only moves req_addr when no request would be left dangling
    retarget     = redirect && (((state == FETCH) && imem_ack) ||
                                (state == HOLD) || (state == IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      hold_instr  <= '0;
      hold_pc4    <= '0;
      IF_ID_instr <= '0;
      IF_ID_pc4   <= '0;
      IF_ID_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= target;
      IF_ID_instr <= '0;
      IF_ID_valid <= 1'b0;
      if (retarget) req_addr <= target;
    end else if (load_mem) begin
      IF_ID_instr <= imem_rdata;
      IF_ID_pc4   <= req_addr + 32'd4;
      IF_ID_valid <= 1'b1;
      pc          <= req_addr + 32'd4;
      req_addr    <= req_addr + 32'd4;
    end else if (load_hold) begin
      IF_ID_instr <= hold_instr;
      IF_ID_pc4   <= hold_pc4;
      IF_ID_valid <= 1'b1;
      pc          <= hold_pc4;
      req_addr    <= hold_pc4;
    end else if (capture_hold) begin
      hold_instr  <= imem_rdata;
      hold_pc4    <= req_addr + 32'd4;
    end else if ((state == DROP) && imem_ack) begin
      req_addr    <= pc;
    end
  end

`ifdef IFU_FETCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      fetch_cnt <= '0;
    else if (load_mem || load_hold)  fetch_cnt <= fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then randomized traffic
// against a transaction-level reference model (fetch counter checked when IFU_FETCH_CNT_EN is defined).
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] IF_ID_instr, IF_ID_pc4;
  logic        IF_ID_valid;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid)
`ifdef IFU_FETCH_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: an outstanding request (possibly junk after a redirect),
  // a parked word waiting for Decode, and the IF/ID contents.
  bit          m_started, m_req, m_junk, m_parked, m_v;
  logic [31:0] m_addr, m_next, m_park_w, m_park_pc4, m_instr, m_pc4, m_cnt;

  task automatic model_reset();
    m_started = 0; m_req = 0; m_junk = 0; m_parked = 0; m_v = 0;
    m_addr = RST_PC; m_next = RST_PC; m_park_w = '0; m_park_pc4 = '0;
    m_instr = '0; m_pc4 = '0; m_cnt = '0;
  endtask

  task automatic model_load(input logic [31:0] w, input logic [31:0] pc4);
    m_v = 1; m_instr = w; m_pc4 = pc4; m_cnt = m_cnt + 1;
    m_addr = pc4; m_next = pc4;
  endtask

  task automatic model_step(input bit r, input logic [31:0] tgt_raw, input bit s,
                            input bit a_in, input logic [31:0] d);
    logic [31:0] tgt;
    bit a;
    tgt = tgt_raw & 32'hFFFF_FFFC;
    a = a_in && m_req;
    if (!m_started) begin
      m_started = 1; m_req = 1;
      if (r) begin m_next = tgt; m_addr = tgt; m_v = 0; m_instr = '0; end
    end else if (r) begin
      m_v = 0; m_instr = '0; m_next = tgt;
      if (m_parked) begin
        m_parked = 0; m_req = 1; m_addr = tgt;
      end else if (m_req && !m_junk) begin
        if (a) m_addr = tgt;
        else   m_junk = 1;
      end
    end else if (m_junk) begin
      if (a) begin m_junk = 0; m_addr = m_next; end
    end else if (m_parked) begin
      if (!s) begin m_parked = 0; m_req = 1; model_load(m_park_w, m_park_pc4); end
    end else if (a) begin
      if (!s || !m_v) model_load(d, m_addr + 32'd4);
      else begin m_parked = 1; m_req = 0; m_park_w = d; m_park_pc4 = m_addr + 32'd4; end
    end
  endtask

  task automatic check_all();
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    check("imem_addr", imem_addr, m_addr);
    check("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_v});
    check("IF_ID_instr", IF_ID_instr, m_instr);
    check("IF_ID_pc4", IF_ID_pc4, m_pc4);
`ifdef IFU_FETCH_CNT_EN
    check("fetch_cnt", fetch_cnt, m_cnt);
`endif
  endtask

  task automatic cycle(input bit r, input logic [31:0] tgt, input bit s,
                       input bit a, input logic [31:0] d);
    redirect = r; redirect_pc = tgt; stall = s;
    imem_ack = a && imem_req; imem_rdata = d;
    @(posedge clk);
    model_step(r, tgt, s, imem_ack, d);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    check("reset_addr", imem_addr, RST_PC);
    rst_n = 1'b1;

    cycle(0, '0, 0, 0, '0);
    check("first_req", {31'b0, imem_req}, 32'd1);
    cycle(0, '0, 0, 1, 32'h0800000b);
    check("load1_instr", IF_ID_instr, 32'h0800000b);
    check("load1_pc4", IF_ID_pc4, 32'd4);
    cycle(0, '0, 0, 1, 32'h20080042);
    check("load2_instr", IF_ID_instr, 32'h20080042);
    check("load2_pc4", IF_ID_pc4, 32'd8);
    cycle(0, '0, 1, 1, 32'h01095022);
    check("stall_req", {31'b0, imem_req}, 32'd0);
    check("stall_hold", IF_ID_instr, 32'h20080042);
    cycle(0, '0, 0, 0, '0);
    check("unstall_instr", IF_ID_instr, 32'h01095022);
    cycle(0, '0, 1, 1, 32'h11111111);
    cycle(1, 32'h2C, 1, 0, '0);
    check("redir_valid", {31'b0, IF_ID_valid}, 32'd0);
    check("redir_instr", IF_ID_instr, 32'd0);
    check("redir_addr", imem_addr, 32'h2C);
    cycle(1, 32'h10, 0, 1, 32'h22222222);
    cycle(1, 32'h07, 0, 0, '0);
    check("drop_addr0", imem_addr, 32'h10);
    cycle(0, '0, 0, 0, '0);
    check("drop_addr1", imem_addr, 32'h10);
    cycle(0, '0, 0, 1, 32'h33333333);
    check("after_drop_addr", imem_addr, 32'h04);
    check("drop_discard", {31'b0, IF_ID_valid}, 32'd0);
    cycle(0, '0, 0, 1, 32'hac0b000c);
    check("pre_flush", IF_ID_instr, 32'hac0b000c);
    cycle(1, 32'h40, 1, 0, '0);
    check("flush_instr", IF_ID_instr, 32'd0);
    check("flush_pc4", IF_ID_pc4, 32'd8);
    cycle(0, '0, 0, 1, '0);
    cycle(1, 32'hFFFF_FFFC, 0, 1, 32'h5);
    cycle(0, '0, 0, 1, 32'h0000_1234);
    check("wrap_pc4", IF_ID_pc4, 32'd0);
    check("wrap_addr", imem_addr, 32'd0);
`ifdef IFU_FETCH_CNT_EN
    check("cnt_directed", fetch_cnt, 32'd5);
`endif

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 8, $urandom, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 60, $urandom);
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
